// File: rtl/core_pkg.sv
// Shared ID/EX definitions: datapath widths, ALU opcode encodings and the
// packed payload carried across the ID/EX boundary.
package core_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0]   rs1;
        logic [DATA_W-1:0]   rs2;
        logic [DATA_W-1:0]   imm;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic [REG_AW-1:0]   rd;
        logic                reg_write;
    } id_ex_payload_t;

    localparam int ID_EX_W = $bits(id_ex_payload_t);

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready_o depends only on registered state, never on out_ready_i.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         in_fire;
    logic         out_fire;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    assign in_fire  = in_valid_i & ~skid_valid_q;
    assign out_fire = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            // Kill both entries; payload registers keep their contents.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register: packs decoded operands/controls into one payload
// and passes them through a 2-entry skid buffer toward the EX stage.
module id_ex_skid_reg #(
    parameter int DATA_W   = core_pkg::DATA_W,
    parameter int REG_AW   = core_pkg::REG_AW,
    parameter int ALU_OP_W = core_pkg::ALU_OP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_rs1_data,
    input  logic [DATA_W-1:0]   in_rs2_data,
    input  logic [DATA_W-1:0]   in_imm,
    input  logic                in_alu_src,
    input  logic [ALU_OP_W-1:0] in_alu_op,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic                in_reg_write,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rs1_data,
    output logic [DATA_W-1:0]   out_rs2_data,
    output logic [DATA_W-1:0]   out_imm,
    output logic                out_alu_src,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [REG_AW-1:0]   out_rd,
    output logic                out_reg_write
);

    core_pkg::id_ex_payload_t in_pkt;
    core_pkg::id_ex_payload_t out_pkt;

    always_comb begin
        in_pkt           = '0;
        in_pkt.rs1       = in_rs1_data;
        in_pkt.rs2       = in_rs2_data;
        in_pkt.imm       = in_imm;
        in_pkt.alu_src   = in_alu_src;
        in_pkt.alu_op    = in_alu_op;
        in_pkt.rd        = in_rd;
        in_pkt.reg_write = in_reg_write;
    end

    skid_buffer #(
        .W (core_pkg::ID_EX_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_pkt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_pkt)
    );

    assign out_rs1_data  = out_pkt.rs1;
    assign out_rs2_data  = out_pkt.rs2;
    assign out_imm       = out_pkt.imm;
    assign out_alu_src   = out_pkt.alu_src;
    assign out_alu_op    = out_pkt.alu_op;
    assign out_rd        = out_pkt.rd;
    // A bubble must never write back, even though the payload is held.
    assign out_reg_write = out_pkt.reg_write & out_valid;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: queue-based FIFO model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_id_ex_skid_reg;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        reg_write;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_alu_src;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data, out_rs2_data, out_imm;
    logic        out_alu_src;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_alu_src    (in_alu_src),
        .in_alu_op     (in_alu_op),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rs1_data  (out_rs1_data),
        .out_rs2_data  (out_rs2_data),
        .out_imm       (out_imm),
        .out_alu_src   (out_alu_src),
        .out_alu_op    (out_alu_op),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write)
    );

    // ---------------- behavioural model: FIFO of depth 2 ----------------
    pkt_t q[$];
    pkt_t last_head;

    function automatic pkt_t zero_pkt();
        pkt_t p;
        p.rs1 = '0; p.rs2 = '0; p.imm = '0; p.alu_src = 1'b0;
        p.alu_op = '0; p.rd = '0; p.reg_write = 1'b0;
        return p;
    endfunction

    initial last_head = zero_pkt();

    always @(negedge rst_n) begin
        q.delete();
        last_head = zero_pkt();
    end

    always @(posedge clk) begin
        if (rst_n) begin
            pkt_t cur;
            bit in_fire_m, out_fire_m;
            cur.rs1 = in_rs1_data; cur.rs2 = in_rs2_data; cur.imm = in_imm;
            cur.alu_src = in_alu_src; cur.alu_op = in_alu_op;
            cur.rd = in_rd; cur.reg_write = in_reg_write;
            in_fire_m  = in_valid && (q.size() < 2);
            out_fire_m = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (out_fire_m) void'(q.pop_front());
                if (in_fire_m) q.push_back(cur);
                if (q.size() > 0) last_head = q[0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        ev = (q.size() > 0);
        check("m_out_valid", 32'(out_valid), 32'(ev));
        check("m_in_ready",  32'(in_ready),  32'(q.size() < 2));
        check("m_rs1",       out_rs1_data,   last_head.rs1);
        check("m_rs2",       out_rs2_data,   last_head.rs2);
        check("m_imm",       out_imm,        last_head.imm);
        check("m_alu_src",   32'(out_alu_src), 32'(last_head.alu_src));
        check("m_alu_op",    32'(out_alu_op),  32'(last_head.alu_op));
        check("m_rd",        32'(out_rd),      32'(last_head.rd));
        check("m_reg_write", 32'(out_reg_write), 32'(last_head.reg_write && ev));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic rw);
        in_valid     = 1'b1;
        in_rs1_data  = rs1;
        in_rs2_data  = rs2;
        in_imm       = imm;
        in_alu_src   = imm[0];
        in_alu_op    = imm[3:0];
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        in_alu_src = 1'b0; in_alu_op = '0; in_rd = '0; in_reg_write = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_imm",   out_imm,        32'd0);

        // Streaming, 1 packet per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(32'h100 + 32'(i), 32'h200 + 32'(i), 32'(i), 5'(i), 1'b1);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_imm",   out_imm,        32'(i));
        end
        idle();
        step();
        check("stream_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges while holding a packet.
        out_ready = 1'b0;
        send(32'h11, 32'h22, 32'h55, 5'd3, 1'b1);
        step();
        check("prerst_valid", 32'(out_valid), 32'd1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_imm",   out_imm,        32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Backpressure: A in main, B in skid, C waits at the input.
        out_ready = 1'b0;
        send(32'hA1, 32'hAAAA0001, 32'hA, 5'd1, 1'b1);
        step();
        send(32'hB1, 32'hBBBB0002, 32'hB, 5'd2, 1'b1);
        step();
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_head_A",        out_rs2_data,  32'hAAAA0001);
        send(32'hC1, 32'hCCCC0003, 32'hC, 5'd4, 1'b0);
        step();
        check("bp_hold_A",        out_rs2_data,  32'hAAAA0001);
        out_ready = 1'b1;
        step();
        check("bp_head_B",        out_rs2_data,  32'hBBBB0002);
        check("bp_ready_again",   32'(in_ready), 32'd1);
        step();
        check("bp_head_C",        out_rs2_data,  32'hCCCC0003);
        idle();
        step();
        check("bp_drained",       32'(out_valid), 32'd0);

        // Flush with both entries occupied and a packet at the input.
        out_ready = 1'b0;
        send(32'hD1, 32'hDDDD0004, 32'hD, 5'd6, 1'b1);
        step();
        send(32'hE1, 32'hEEEE0005, 32'hE, 5'd7, 1'b1);
        step();
        flush = 1'b1;
        send(32'hF1, 32'hFFFF0006, 32'hF, 5'd8, 1'b1);
        step();
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        check("flush_valid",    32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready),  32'd1);
        step();
        check("flush_no_ghost", 32'(out_valid), 32'd0);

        // Flush while an input packet actually fires: it must be dropped.
        send(32'h61, 32'h62, 32'h63, 5'd9, 1'b1);
        step();
        flush = 1'b1;
        send(32'h71, 32'h72, 32'h73, 5'd10, 1'b1);
        step();
        flush = 1'b0;
        idle();
        check("flush_fire_drop", 32'(out_valid), 32'd0);
        step();
        check("flush_fire_gone", 32'(out_valid), 32'd0);

        // Bubble masking of reg_write.
        send(32'h5, 32'h50, 32'h500, 5'd5, 1'b1);
        step();
        check("bub_rw_live", 32'(out_reg_write), 32'd1);
        idle();
        step();
        check("bub_valid", 32'(out_valid),     32'd0);
        check("bub_rw",    32'(out_reg_write), 32'd0);
        check("bub_rd",    32'(out_rd),        32'd5);

        // Simultaneous in_fire and out_fire with skid empty.
        out_ready = 1'b0;
        send(32'h81, 32'h82, 32'h1111, 5'd11, 1'b0);
        step();
        out_ready = 1'b1;
        send(32'h91, 32'h92, 32'h2222, 5'd12, 1'b1);
        step();
        idle();
        check("sim_out_imm",  out_imm,         32'h2222);
        check("sim_in_ready", 32'(in_ready),   32'd1);
        check("sim_valid",    32'(out_valid),  32'd1);
        step();
        check("sim_no_dup",   32'(out_valid),  32'd0);

        // x0 destination passes through unchanged.
        send(32'h1, 32'h2, 32'h3, 5'd0, 1'b1);
        step();
        idle();
        check("x0_rd", 32'(out_rd),        32'd0);
        check("x0_rw", 32'(out_reg_write), 32'd1);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
